// File: rtl/ram_dma.sv
// ram_dma: single-channel word DMA that copies a block between two addresses of one
// RAM port, or fills a block with a constant pattern. A command is accepted from IDLE
// only. Copy alternates READ/WRITE per word; fill writes one word per cycle.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, mode         command strobe (sampled in IDLE only), 0 = copy / 1 = fill
//   src_addr, dst_addr  starting word addresses (wrap modulo 2^ADDR_WIDTH)
//   len                 word count, 0..2^ADDR_WIDTH
//   fill_data           pattern for fill mode
//   busy, done          busy outside IDLE; done is a one-cycle pulse in DONE
//   mem_*               single RAM port with a combinational read path

package ram_dma_pkg;
    localparam int DEFAULT_RAM_ADDR_WIDTH = 10;
endpackage

module ram_dma #(
    parameter int ADDR_WIDTH = ram_dma_pkg::DEFAULT_RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [31:0]           fill_data,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wr_data,
    output logic [3:0]            mem_wr_strobe,
    input  logic [31:0]           mem_rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;

    state_t                state;
    state_t                state_nxt;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [31:0]           data_q;
    logic [31:0]           fill_q;

    // Next-state decode. The count is one wider than the address so that a full
    // 2^ADDR_WIDTH transfer is representable; the last WRITE is the one that sees 1.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len == CNT_ZERO) begin
                        state_nxt = DONE;
                    end else if (mode) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ:  state_nxt = WRITE;
            WRITE: begin
                if (count == CNT_ONE) begin
                    state_nxt = DONE;
                end else if (mode_q) begin
                    state_nxt = WRITE;
                end else begin
                    state_nxt = READ;
                end
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port and status decode from registered state only, so start never
    // reaches the RAM combinationally. Address and data are forced to zero when idle.
    always_comb begin
        busy          = (state != IDLE);
        done          = (state == DONE);
        mem_rd_en     = 1'b0;
        mem_wr_en     = 1'b0;
        mem_addr      = '0;
        mem_wr_data   = '0;
        mem_wr_strobe = 4'b0000;
        unique case (state)
            READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = src_ptr;
            end
            WRITE: begin
                mem_wr_en     = 1'b1;
                mem_wr_strobe = 4'b1111;
                mem_addr      = dst_ptr;
                mem_wr_data   = mode_q ? fill_q : data_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            data_q  <= '0;
            fill_q  <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    // Operands are captured once; later changes on the inputs are ignored.
                    if (start) begin
                        mode_q  <= mode;
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        count   <= len;
                        fill_q  <= fill_data;
                    end
                end
                READ: begin
                    data_q  <= mem_rd_data;
                    src_ptr <= src_ptr + ADDR_ONE;
                end
                WRITE: begin
                    dst_ptr <= dst_ptr + ADDR_ONE;
                    count   <= count - CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma.sv
module tb_ram_dma;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, 8-bit word address
    logic        rst, start, mode;
    logic [7:0]  src_addr, dst_addr;
    logic [8:0]  len;
    logic [31:0] fill_data;
    logic        busy, done, mem_rd_en, mem_wr_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wr_data, mem_rd_data;
    logic [3:0]  mem_wr_strobe;

    // second instance, 4-bit word address for the wrap case
    logic        start4, mode4;
    logic [3:0]  src4, dst4;
    logic [4:0]  len4;
    logic [31:0] fill4;
    logic        busy4, done4, rd4, wr4;
    logic [3:0]  addr4;
    logic [31:0] wdata4, rdata4;
    logic [3:0]  strb4;

    ram_dma #(.ADDR_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_strobe(mem_wr_strobe),
        .mem_rd_data(mem_rd_data)
    );

    ram_dma #(.ADDR_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4),
        .src_addr(src4), .dst_addr(dst4), .len(len4), .fill_data(fill4),
        .busy(busy4), .done(done4), .mem_rd_en(rd4), .mem_wr_en(wr4),
        .mem_addr(addr4), .mem_wr_data(wdata4), .mem_wr_strobe(strb4),
        .mem_rd_data(rdata4)
    );

    // RAM models: combinational read, byte-strobed write, bench preload port
    logic [31:0] ram  [256];
    logic [31:0] ram4 [16];
    logic        pk_en, pk_clr, pk_sel;
    logic [7:0]  pk_a;
    logic [31:0] pk_d;

    assign mem_rd_data = ram[mem_addr];
    assign rdata4      = ram4[addr4];

    always @(posedge clk) begin
        if (pk_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            for (int i = 0; i < 16; i++) ram4[i] <= '0;
        end else if (pk_en) begin
            if (pk_sel) ram4[pk_a[3:0]] <= pk_d;
            else        ram[pk_a]       <= pk_d;
        end
        if (mem_wr_en)
            for (int b = 0; b < 4; b++)
                if (mem_wr_strobe[b]) ram[mem_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
        if (wr4)
            for (int b = 0; b < 4; b++)
                if (strb4[b]) ram4[addr4][8*b +: 8] <= wdata4[8*b +: 8];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic sel, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pk_en = 1'b1; pk_sel = sel; pk_a = a; pk_d = d;
        @(posedge clk);
        #1 pk_en = 1'b0;
    endtask

    // start accepted at the next rising edge (edge 0); operands scrambled right after
    task automatic issue(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] l, input logic [31:0] f);
        @(negedge clk);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
        @(posedge clk);
        #1;
        start = 1'b0; mode = ~m; src_addr = 8'h99; dst_addr = 8'hAA; len = 9'd7;
        fill_data = 32'hBAD0BAD0;
    endtask

    // per-run observations, cycle k = k-th cycle after edge 0
    int          done_cyc, n_done, busy_cyc, end_cyc, wr_first;
    bit          post_rst_zero, strb_ok;
    logic [7:0]  rd_q[$];
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];

    task automatic trace(input int budget, input int inj_cyc, input int rst_cyc);
        done_cyc = 0; n_done = 0; busy_cyc = 0; end_cyc = 0; wr_first = 0;
        post_rst_zero = 1'b0; strb_ok = 1'b1;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (rst) begin
                rst = 1'b0;
                post_rst_zero = !(busy | done | mem_rd_en | mem_wr_en) &&
                                mem_wr_strobe == 4'h0 && mem_addr == 8'h00 && mem_wr_data == 32'h0;
            end
            if (mem_rd_en) rd_q.push_back(mem_addr);
            if (mem_wr_en) begin
                if (wr_first == 0) wr_first = k;
                wa_q.push_back(mem_addr);
                wd_q.push_back(mem_wr_data);
                if (mem_wr_strobe != 4'hF) strb_ok = 1'b0;
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (busy) busy_cyc++;
            if (!busy) begin
                end_cyc = k;
                break;
            end
            if (k == inj_cyc) begin
                start = 1'b1; mode = 1'b1; src_addr = 8'h00; dst_addr = 8'h80;
                len = 9'd2; fill_data = 32'h55555555;
            end
            if (k == rst_cyc) rst = 1'b1;
        end
    endtask

    logic [3:0] r4_q[$];
    logic [3:0] w4_q[$];
    int         n_done4, bad;

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        fill_data = '0; start4 = 1'b0; mode4 = 1'b0; src4 = '0; dst4 = '0; len4 = '0;
        fill4 = '0; pk_en = 1'b0; pk_clr = 1'b1; pk_sel = 1'b0; pk_a = '0; pk_d = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", {mem_rd_en, mem_wr_en, mem_wr_strobe}, 0);
        check("rst_addr_data", {mem_addr, mem_wr_data}, 0);
        rst = 1'b0; pk_clr = 1'b0;

        // copy 4 words 0x10 -> 0x40
        for (int i = 0; i < 4; i++) poke(1'b0, 8'h10 + 8'(i), 32'hA000_0000 + i);
        issue(1'b0, 8'h10, 8'h40, 9'd4, 32'h0);
        trace(30, 0, 0);
        check("copy_done_cyc", done_cyc, 9);
        check("copy_n_done", n_done, 1);
        check("copy_busy_cycles", busy_cyc, 9);
        check("copy_idle_cyc", end_cyc, 10);
        check("copy_first_write", wr_first, 2);
        check("copy_n_reads", rd_q.size(), 4);
        check("copy_n_writes", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("copy_rd_addr", rd_q[i], 8'h10 + 8'(i));
            check("copy_wr_addr", wa_q[i], 8'h40 + 8'(i));
            check("copy_ram", ram[8'h40 + 8'(i)], 32'hA000_0000 + i);
        end

        // fill 3 words at 0x20
        issue(1'b1, 8'h77, 8'h20, 9'd3, 32'hDEADBEEF);
        trace(20, 0, 0);
        check("fill_done_cyc", done_cyc, 4);
        check("fill_first_write", wr_first, 1);
        check("fill_n_reads", rd_q.size(), 0);
        check("fill_n_writes", wa_q.size(), 3);
        check("fill_strobe", strb_ok, 1);
        for (int i = 0; i < 3; i++) begin
            check("fill_wr_addr", wa_q[i], 8'h20 + 8'(i));
            check("fill_ram", ram[8'h20 + 8'(i)], 32'hDEADBEEF);
        end

        // zero length, with a start offered in the DONE cycle
        issue(1'b0, 8'h10, 8'h50, 9'd0, 32'h0);
        trace(10, 1, 0);
        check("zero_done_cyc", done_cyc, 1);
        check("zero_idle_cyc", end_cyc, 2);
        check("zero_accesses", rd_q.size() + wa_q.size(), 0);
        @(negedge clk);
        check("zero_no_queue", busy, 0);
        check("zero_ram80", ram[8'h80], 0);

        // second start mid-copy must be ignored
        issue(1'b0, 8'h10, 8'h60, 9'd4, 32'h0);
        trace(30, 3, 0);
        check("busy_done_cyc", done_cyc, 9);
        check("busy_n_done", n_done, 1);
        check("busy_n_writes", wa_q.size(), 4);
        check("busy_ram63", ram[8'h63], 32'hA000_0003);
        check("busy_ram80", ram[8'h80], 0);

        // overlapping ranges, ascending order, no correction
        issue(1'b0, 8'h10, 8'h11, 9'd3, 32'h0);
        trace(20, 0, 0);
        check("ovl_ram11", ram[8'h11], 32'hA000_0000);
        check("ovl_ram13", ram[8'h13], 32'hA000_0000);

        // reset during the 2nd WRITE of a 5-word fill
        issue(1'b1, 8'h00, 8'h30, 9'd5, 32'h12345678);
        trace(20, 0, 2);
        check("rstmid_n_done", n_done, 0);
        check("rstmid_outputs_zero", post_rst_zero, 1);
        check("rstmid_idle_cyc", end_cyc, 3);
        check("rstmid_le2_writes", wa_q.size() <= 2, 1);
        check("rstmid_ram30", ram[8'h30], 32'h12345678);
        check("rstmid_ram32", ram[8'h32], 0);
        issue(1'b1, 8'h00, 8'h30, 9'd1, 32'hCAFEF00D);
        trace(10, 0, 0);
        check("after_rst_done_cyc", done_cyc, 2);
        check("after_rst_ram30", ram[8'h30], 32'hCAFEF00D);

        // full-size fill, wraps through address 0
        issue(1'b1, 8'h00, 8'h05, 9'd256, 32'h0F0F0F0F);
        trace(600, 0, 0);
        check("full_done_cyc", done_cyc, 257);
        check("full_n_writes", wa_q.size(), 256);
        check("full_first_addr", wa_q[0], 8'h05);
        check("full_last_addr", wa_q[255], 8'h04);
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] != 32'h0F0F0F0F) bad++;
        check("full_ram_words_wrong", bad, 0);

        // 4-bit instance: copy wraps the source pointer
        poke(1'b1, 8'h0E, 32'hB000_0000);
        poke(1'b1, 8'h0F, 32'hB000_0001);
        poke(1'b1, 8'h00, 32'hB000_0002);
        @(negedge clk);
        start4 = 1'b1; src4 = 4'hE; dst4 = 4'h2; len4 = 5'd3;
        @(posedge clk);
        #1 start4 = 1'b0;
        n_done4 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rd4) r4_q.push_back(addr4);
            if (wr4) w4_q.push_back(addr4);
            if (done4) n_done4++;
        end
        check("wrap_n_done", n_done4, 1);
        check("wrap_rd_addrs", {r4_q.size() == 3 ? {r4_q[0], r4_q[1], r4_q[2]} : 12'hFFF}, 12'hEF0);
        check("wrap_wr_addrs", {w4_q.size() == 3 ? {w4_q[0], w4_q[1], w4_q[2]} : 12'hFFF}, 12'h234);
        check("wrap_ram2", ram4[2], 32'hB000_0000);
        check("wrap_ram4", ram4[4], 32'hB000_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_dma.md
RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default DEFAULT_RAM_ADDR_WIDTH, meaning word-address bits of the attached RAM port.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, command request; sampled only in IDLE.
REQ-006 Port mode, input, 1, operation select: 0 = copy, 1 = fill; sampled with start.
REQ-007 Port src_addr, input, ADDR_WIDTH, copy source word address; sampled with start.
REQ-008 Port dst_addr, input, ADDR_WIDTH, destination word address; sampled with start.
REQ-009 Port len, input, ADDR_WIDTH+1, transfer length in words (0..2^ADDR_WIDTH); sampled with start.
REQ-010 Port fill_data, input, 32 (rv32::word), fill pattern; sampled with start.
REQ-011 Port busy, output, 1, high in any state other than IDLE.
REQ-012 Port done, output, 1, single-cycle completion pulse.
REQ-013 Port mem_rd_en, output, 1, RAM read enable.
REQ-014 Port mem_wr_en, output, 1, RAM write enable.
REQ-015 Port mem_addr, output, ADDR_WIDTH, RAM word address.
REQ-016 Port mem_wr_data, output, 32 (rv32::word), RAM write data.
REQ-017 Port mem_wr_strobe, output, 4, RAM byte write strobe.
REQ-018 Port mem_rd_data, input, 32 (rv32::word), RAM read data; combinational, valid in the same cycle as mem_rd_en/mem_addr.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, READ, WRITE and DONE.
REQ-020 In IDLE with start=1, the block SHALL latch mode, src_addr, dst_addr, len and fill_data; next state is DONE if len=0, WRITE if mode=1, otherwise READ.
REQ-021 In IDLE with start=0, the state SHALL remain IDLE.
REQ-022 In READ, the block SHALL drive mem_rd_en=1 and mem_addr=current source pointer, capture mem_rd_data into a data register at the clock edge, advance the source pointer by 1, and go to WRITE.
REQ-023 In WRITE, the block SHALL drive mem_wr_en=1, mem_wr_strobe=4'b1111, mem_addr=current destination pointer, and mem_wr_data=captured word (copy) or latched fill_data (fill).
REQ-024 Each WRITE cycle SHALL advance the destination pointer by 1 and decrement the remaining count by 1.
REQ-025 From WRITE, the next state SHALL be DONE when the remaining count reaches 0, otherwise READ (copy) or WRITE (fill).
REQ-026 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-027 Outside READ, mem_rd_en SHALL be 0; outside WRITE, mem_wr_en=0 and mem_wr_strobe=4'b0000.
REQ-028 When neither enable is high, mem_addr and mem_wr_data SHALL be 0.
REQ-029 Memory-port outputs SHALL be decoded from registered state and pointers only, with no combinational path from start.
REQ-030 Latency: with start accepted at edge 0, copy of N words SHALL occupy READ/WRITE alternately for cycles 1..2N and DONE at cycle 2N+1; fill SHALL occupy WRITE for cycles 1..N and DONE at cycle N+1; len=0 SHALL give DONE at cycle 1 with no memory access.
REQ-031 Source and destination pointers SHALL wrap modulo 2^ADDR_WIDTH; len=2^ADDR_WIDTH SHALL transfer every word exactly once.
REQ-032 start SHALL be ignored while busy=1 and in the DONE cycle; no command is queued.
REQ-033 Changes on src_addr, dst_addr, len, mode or fill_data while busy SHALL NOT affect the operation in progress.
REQ-034 Overlapping source and destination ranges SHALL be processed in ascending address order with no overlap correction; each word is read immediately before its write.

Reset
REQ-035 On a rising clk edge with rst=1, the state SHALL go to IDLE and all pointers, the count and the data register SHALL clear to 0, regardless of current state.
REQ-036 After reset, busy=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_wr_strobe=0, mem_addr=0 and mem_wr_data=0.
REQ-037 Reset mid-transfer SHALL abort the transfer with no done pulse; words already written stay written.
REQ-038 rst SHALL take priority over start in the same cycle.

Verification
REQ-039 Copy: RAM[0x10..0x13]=A0..A3, start mode=0 src=0x10 dst=0x40 len=4 -> RAM[0x40..0x43]=A0..A3, done at cycle 9, busy for cycles 1..9.
REQ-040 Fill: start mode=1 dst=0x20 len=3 fill_data=0xDEADBEEF -> writes at cycles 1..3 to 0x20..0x22 with strobe 4'hF, done at cycle 4.
REQ-041 Zero length: len=0 -> no mem_rd_en/mem_wr_en pulses, done at cycle 1, IDLE at cycle 2.
REQ-042 Wrap: ADDR_WIDTH=4, copy src=0xE dst=0x2 len=3 -> reads 0xE,0xF,0x0 and writes 0x2,0x3,0x4 in order.
REQ-043 Busy start: a second start with new operands mid-copy -> ignored, original transfer completes unchanged, exactly one done pulse.
REQ-044 Reset mid-fill: rst during the 2nd WRITE of len=5 -> at most 2 words written, all outputs 0 next cycle, no done pulse, next start executes normally.
